// File: rtl/stack_rpn_sequencer.sv
// stack_rpn_sequencer: turns RPN instructions into single push/pop requests
// for an external stack, computes binary ops locally and tracks a shadow depth
// so that underflow/overflow is rejected before any stack traffic.
module stack_rpn_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int DW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ins_valid,
  output logic             ins_ready,
  input  logic [2:0]       ins_op,
  input  logic [WIDTH-1:0] ins_imm,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_wdata,
  input  logic [WIDTH-1:0] stk_rdata,
  input  logic             stk_done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic [DW-1:0]    depth,
  output logic             err,
  output logic             busy
);

  localparam logic [2:0] OpPushi = 3'b000;
  localparam logic [2:0] OpAdd   = 3'b001;
  localparam logic [2:0] OpSub   = 3'b010;
  localparam logic [2:0] OpAnd   = 3'b011;
  localparam logic [2:0] OpOr    = 3'b100;
  localparam logic [2:0] OpXor   = 3'b101;
  localparam logic [2:0] OpDup   = 3'b110;
  localparam logic [2:0] OpDrop  = 3'b111;

  localparam logic [DW-1:0] DepthFull = DW'(DEPTH);
  localparam logic [DW-1:0] DepthOne  = DW'(1);
  localparam logic [DW-1:0] DepthTwo  = DW'(2);

  typedef enum logic [2:0] {
    IDLE, POP_A, WAIT_A, POP_B, WAIT_B, EXEC, PUSH, WAIT_P
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q, zero_q;
  logic [DW-1:0]    depth_q;
  logic             err_q;
  logic             dupSecond_q;

  logic             accept;
  logic             legal;
  logic [WIDTH:0]   sumFull, diffFull;
  logic [WIDTH-1:0] aluResult;
  logic             aluCarry;

  assign accept   = ins_valid && (state_q == IDLE);
  assign sumFull  = {1'b0, b_q} + {1'b0, a_q};
  assign diffFull = {1'b0, b_q} - {1'b0, a_q};

  // Legality of the incoming instruction against the shadow depth
  always_comb begin
    legal = 1'b0;
    case (ins_op)
      OpPushi: legal = (depth_q < DepthFull);
      OpDup:   legal = (depth_q >= DepthOne) && (depth_q < DepthFull);
      OpDrop:  legal = (depth_q >= DepthOne);
      default: legal = (depth_q >= DepthTwo);
    endcase
  end

  // ALU: B is the older operand, A the top; the top bit of the widened
  // difference is the borrow, so it doubles as the SUB carry flag
  always_comb begin
    aluResult = '0;
    aluCarry  = carry_q;
    case (op_q)
      OpAdd: begin
        aluResult = sumFull[WIDTH-1:0];
        aluCarry  = sumFull[WIDTH];
      end
      OpSub: begin
        aluResult = diffFull[WIDTH-1:0];
        aluCarry  = diffFull[WIDTH];
      end
      OpAnd:   aluResult = b_q & a_q;
      OpOr:    aluResult = b_q | a_q;
      OpXor:   aluResult = b_q ^ a_q;
      default: aluResult = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; in IDLE the live opcode decides, later the latched one
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && legal) begin
          state_d = (ins_op == OpPushi) ? PUSH : POP_A;
        end
      end
      POP_A: state_d = WAIT_A;
      WAIT_A: begin
        if (stk_done) begin
          if (op_q == OpDrop) begin
            state_d = IDLE;
          end else if (op_q == OpDup) begin
            state_d = PUSH;
          end else begin
            state_d = POP_B;
          end
        end
      end
      POP_B: state_d = WAIT_B;
      WAIT_B: begin
        if (stk_done) begin
          state_d = EXEC;
        end
      end
      EXEC: state_d = PUSH;
      PUSH: state_d = WAIT_P;
      WAIT_P: begin
        if (stk_done) begin
          state_d = ((op_q == OpDup) && !dupSecond_q) ? PUSH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the current state only
  always_comb begin
    ins_ready = 1'b0;
    busy      = 1'b1;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        ins_ready = 1'b1;
        busy      = 1'b0;
      end
      POP_A, POP_B: stk_pop  = 1'b1;
      PUSH:         stk_push = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operands, push data, flags, shadow depth and the error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= OpPushi;
      a_q         <= '0;
      b_q         <= '0;
      wdata_q     <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      depth_q     <= '0;
      err_q       <= 1'b0;
      dupSecond_q <= 1'b0;
    end else begin
      err_q <= accept && !legal;
      if (accept) begin
        op_q        <= ins_op;
        dupSecond_q <= 1'b0;
        if (legal && (ins_op == OpPushi)) begin
          wdata_q <= ins_imm;
        end
      end
      case (state_q)
        WAIT_A: begin
          if (stk_done) begin
            a_q     <= stk_rdata;
            depth_q <= depth_q - DepthOne;
            if (op_q == OpDup) begin
              wdata_q <= stk_rdata;
            end
          end
        end
        WAIT_B: begin
          if (stk_done) begin
            b_q     <= stk_rdata;
            depth_q <= depth_q - DepthOne;
          end
        end
        EXEC: begin
          wdata_q <= aluResult;
          carry_q <= aluCarry;
          zero_q  <= (aluResult == '0);
        end
        WAIT_P: begin
          if (stk_done) begin
            depth_q     <= depth_q + DepthOne;
            result_q    <= wdata_q;
            dupSecond_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign stk_wdata = wdata_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign depth     = depth_q;
  assign err       = err_q;

endmodule
